dmi_mux: RTL and testbench



---
 rtl/dmi_mux.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dmi_mux.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_mux.sv
// dmi_mux: shares one core-side DMI port among NumChannels DMI masters, on one clock.
// Latency: request push to core_dmi_valid_o is 1 cycle minimum; response path is 0 cycles (1 with DMI_MUX_RESP_REG_EN).
// Backpressure: per-channel request FIFOs refuse pushes when full; issue stalls while MaxOutstanding responses are pending.
//
// Optional feature macro: DMI_MUX_RESP_REG_EN (one-entry response register after the route decode).
//
// Ports:
//   clk_i, rst_i                         core clock, synchronous active-high reset
//   mst_req_i / _valid_i / _ready_o      per-channel DMI request (ReqWidth = $bits(dm::dmi_req_t))
//   mst_resp_o / _valid_o / _ready_i     per-channel DMI response (RespWidth = $bits(dm::dmi_resp_t))
//   core_dmi_req_o / _valid_o / _ready_i arbitrated request towards dm_top
//   core_dmi_resp_i / _valid_i / _ready_o response from dm_top
//   unexp_resp_o                         pulse: response seen with nothing outstanding (dropped)

// Generic synchronous FIFO. Full/empty come from the registered count, so a
// full FIFO refuses a push even if it is popped in the same cycle.
module dmi_mux_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] dat_i,
  input  logic             pop_i,
  output logic [Width-1:0] dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dat_o   = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = dat_i;
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule

module dmi_mux #(
  parameter int NumChannels    = 2,
  parameter int ReqDepth       = 4,
  parameter int MaxOutstanding = 4,
  parameter int ReqWidth       = 41,
  parameter int RespWidth      = 34
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0][ReqWidth-1:0]  mst_req_i,
  input  logic [NumChannels-1:0]                mst_req_valid_i,
  output logic [NumChannels-1:0]                mst_req_ready_o,
  output logic [NumChannels-1:0][RespWidth-1:0] mst_resp_o,
  output logic [NumChannels-1:0]                mst_resp_valid_o,
  input  logic [NumChannels-1:0]                mst_resp_ready_i,
  output logic [ReqWidth-1:0]                   core_dmi_req_o,
  output logic                                  core_dmi_valid_o,
  input  logic                                  core_dmi_ready_i,
  input  logic [RespWidth-1:0]                  core_dmi_resp_i,
  input  logic                                  core_dmi_valid_i,
  output logic                                  core_dmi_ready_o,
  output logic                                  unexp_resp_o
);
  localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChannels - 1);

  logic [NumChannels-1:0][ReqWidth-1:0] head_dat;
  logic [NumChannels-1:0] fifo_full, fifo_empty, fifo_pop, cand;

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] rr_pick, rr_idx, grant;
  logic            pick_found, issue;

  logic [IdxW-1:0] route_head;
  logic            route_full, route_empty, route_pop;

  // ---------------- per-channel request FIFOs ----------------
  for (genvar c = 0; c < NumChannels; c++) begin : g_req_fifo
    dmi_mux_fifo #(.Width(ReqWidth), .Depth(ReqDepth)) u_req_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (mst_req_valid_i[c]),
      .dat_i   (mst_req_i[c]),
      .pop_i   (fifo_pop[c]),
      .dat_o   (head_dat[c]),
      .full_o  (fifo_full[c]),
      .empty_o (fifo_empty[c])
    );
  end

  assign mst_req_ready_o = ~fifo_full;
  assign cand            = ~fifo_empty;

  // ---------------- round-robin arbiter ----------------
  function automatic logic [IdxW-1:0] wrap_idx(logic [IdxW-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= NumChannels) s = s - NumChannels;
    return IdxW'(s);
  endfunction

  always_comb begin
    rr_pick    = rr_ptr_q;
    rr_idx     = rr_ptr_q;
    pick_found = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      rr_idx = wrap_idx(rr_ptr_q, i);
      if (!pick_found && cand[rr_idx]) begin
        pick_found = 1'b1;
        rr_pick    = rr_idx;
      end
    end
  end

  // A stalled offer keeps its channel even if an earlier-in-order candidate appears.
  assign grant            = lock_q ? lock_idx_q : rr_pick;
  // Only registered state feeds valid: no path from ready or master valid.
  assign core_dmi_valid_o = (|cand) & ~route_full;
  assign core_dmi_req_o   = head_dat[grant];
  assign issue            = core_dmi_valid_o & core_dmi_ready_i;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (issue) begin
      rr_ptr_d = (grant == LastIdx) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (core_dmi_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  always_comb begin
    fifo_pop = '0;
    for (int c = 0; c < NumChannels; c++) begin
      fifo_pop[c] = issue && (grant == IdxW'(c));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // ---------------- route FIFO: issuing channel per outstanding request ----------------
  dmi_mux_fifo #(.Width(IdxW), .Depth(MaxOutstanding)) u_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .dat_i   (grant),
    .pop_i   (route_pop),
    .dat_o   (route_head),
    .full_o  (route_full),
    .empty_o (route_empty)
  );

  // Responses with nothing outstanding are accepted and dropped.
  assign unexp_resp_o = core_dmi_valid_i & route_empty;
  assign route_pop    = core_dmi_valid_i & core_dmi_ready_o & ~route_empty;

`ifdef DMI_MUX_RESP_REG_EN
  logic                 resp_vld_q, resp_vld_d;
  logic [IdxW-1:0]      resp_ch_q, resp_ch_d;
  logic [RespWidth-1:0] resp_dat_q, resp_dat_d;
  logic                 resp_drain;

  assign resp_drain = resp_vld_q & mst_resp_ready_i[resp_ch_q];

  always_comb begin
    core_dmi_ready_o = core_dmi_valid_i;
    if (!route_empty) begin
      core_dmi_ready_o = ~resp_vld_q | resp_drain;
    end
  end

  always_comb begin
    resp_vld_d = resp_vld_q;
    resp_ch_d  = resp_ch_q;
    resp_dat_d = resp_dat_q;
    if (route_pop) begin
      resp_vld_d = 1'b1;
      resp_ch_d  = route_head;
      resp_dat_d = core_dmi_resp_i;
    end else if (resp_drain) begin
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld_q <= 1'b0;
      resp_ch_q  <= '0;
      resp_dat_q <= '0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_ch_q  <= resp_ch_d;
      resp_dat_q <= resp_dat_d;
    end
  end

  always_comb begin
    mst_resp_valid_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      mst_resp_o[c] = resp_dat_q;
    end
    mst_resp_valid_o[resp_ch_q] = resp_vld_q;
  end
`else
  // Combinational return path: data fans out to every channel, only valid is steered.
  always_comb begin
    mst_resp_valid_o = '0;
    core_dmi_ready_o = core_dmi_valid_i;
    for (int c = 0; c < NumChannels; c++) begin
      mst_resp_o[c] = core_dmi_resp_i;
    end
    if (!route_empty) begin
      mst_resp_valid_o[route_head] = core_dmi_valid_i;
      core_dmi_ready_o             = mst_resp_ready_i[route_head];
    end
  end
`endif
endmodule

// File: tb/tb_dmi_mux.sv
module tb_dmi_mux;
  localparam int N   = 2;
  localparam int RD  = 4;
  localparam int MO  = 4;
  localparam int RQW = 41;
  localparam int RSW = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_i;
  logic [N-1:0][RQW-1:0]    mst_req_i;
  logic [N-1:0]             mst_req_valid_i, mst_req_ready_o;
  logic [N-1:0][RSW-1:0]    mst_resp_o;
  logic [N-1:0]             mst_resp_valid_o, mst_resp_ready_i;
  logic [RQW-1:0]           core_dmi_req_o;
  logic                     core_dmi_valid_o, core_dmi_ready_i;
  logic [RSW-1:0]           core_dmi_resp_i;
  logic                     core_dmi_valid_i, core_dmi_ready_o, unexp_resp_o;

  dmi_mux #(.NumChannels(N), .ReqDepth(RD), .MaxOutstanding(MO),
            .ReqWidth(RQW), .RespWidth(RSW)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .mst_req_i        (mst_req_i),
    .mst_req_valid_i  (mst_req_valid_i),
    .mst_req_ready_o  (mst_req_ready_o),
    .mst_resp_o       (mst_resp_o),
    .mst_resp_valid_o (mst_resp_valid_o),
    .mst_resp_ready_i (mst_resp_ready_i),
    .core_dmi_req_o   (core_dmi_req_o),
    .core_dmi_valid_o (core_dmi_valid_o),
    .core_dmi_ready_i (core_dmi_ready_i),
    .core_dmi_resp_i  (core_dmi_resp_i),
    .core_dmi_valid_i (core_dmi_valid_i),
    .core_dmi_ready_o (core_dmi_ready_o),
    .unexp_resp_o     (unexp_resp_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RQW-1:0] mk_req(int ch, int k);
    logic [6:0]  a;
    logic [31:0] d;
    a = 7'(ch * 16 + k);
    d = 32'hC0DE_0000 + 32'(ch * 256 + k);
    return {a, 2'b10, d};
  endfunction

  function automatic logic [RSW-1:0] mk_resp(int k);
    logic [31:0] d;
    d = 32'h5A5A_0000 + 32'(k);
    return {d, 2'b00};
  endfunction

  // ---------------- behavioural model: queues per channel, queue of outstanding channels ----------------
  logic [RQW-1:0] mq [N][$];
  int rq[$];
  int rr, lock_ch;
  bit lock, model_on;
  int iss_ch[$];
  int iss_cyc[$];
  logic [RQW-1:0] iss_dat[$];
  int del_ch[$];

  task automatic model_reset();
    for (int c = 0; c < N; c++) mq[c].delete();
    rq.delete();
    rr = 0;
    lock = 0;
    lock_ch = 0;
  endtask

  always @(negedge clk) begin : compare
    logic [N-1:0] e_rrdy, e_rvld;
    logic e_crdy, e_unexp, e_vld, do_resp, do_issue;
    int g, h;
    if (!model_on) begin
      if (rst_i) begin
        model_reset();
        model_on = 1;
      end
    end else begin
      for (int c = 0; c < N; c++) e_rrdy[c] = (mq[c].size() < RD);
      g = -1;
      if (lock) g = lock_ch;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
      e_vld   = (g >= 0) && (rq.size() < MO);
      e_rvld  = '0;
      e_unexp = 0;
      h = -1;
      if (rq.size() > 0) begin
        h = rq[0];
        e_rvld[h] = core_dmi_valid_i;
        e_crdy    = mst_resp_ready_i[h];
      end else begin
        e_crdy  = core_dmi_valid_i;
        e_unexp = core_dmi_valid_i;
      end
      check("req_ready", mst_req_ready_o, e_rrdy);
      check("core_valid", core_dmi_valid_o, e_vld);
      if (e_vld) check("core_req", core_dmi_req_o, mq[g][0]);
      check("resp_valid", mst_resp_valid_o, e_rvld);
      if (h >= 0 && core_dmi_valid_i) check("resp_dat", mst_resp_o[h], core_dmi_resp_i);
      check("core_ready", core_dmi_ready_o, e_crdy);
      check("unexp", unexp_resp_o, e_unexp);

      if (rst_i) begin
        model_reset();
      end else begin
        do_issue = e_vld && core_dmi_ready_i;
        do_resp  = (h >= 0) && core_dmi_valid_i && e_crdy;
        if (do_resp) begin
          del_ch.push_back(h);
          void'(rq.pop_front());
        end
        if (do_issue) begin
          iss_ch.push_back(g);
          iss_cyc.push_back(cyc);
          iss_dat.push_back(mq[g][0]);
          void'(mq[g].pop_front());
          rq.push_back(g);
          rr = (g + 1) % N;
          lock = 0;
        end else if (e_vld) begin
          lock = 1;
          lock_ch = g;
        end
        for (int c = 0; c < N; c++)
          if (mst_req_valid_i[c] && e_rrdy[c]) mq[c].push_back(mst_req_i[c]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1;
    mst_req_valid_i = '0;
    core_dmi_valid_i = 0;
    step(2);
    rst_i = 0;
  endtask

  task automatic clear_logs();
    iss_ch.delete();
    iss_cyc.delete();
    iss_dat.delete();
    del_ch.delete();
  endtask

  task automatic drain(int n);
    core_dmi_valid_i = 1;
    for (int k = 0; k < n; k++) begin
      core_dmi_resp_i = mk_resp(100 + k);
      step();
    end
    core_dmi_valid_i = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int exp_ch2[4];
    int exp_rv2[4];
    rst_i = 1;
    mst_req_i = '0;
    mst_req_valid_i = '0;
    mst_resp_ready_i = '1;
    core_dmi_ready_i = 0;
    core_dmi_resp_i = '0;
    core_dmi_valid_i = 0;
    model_on = 0;
    step(2);
    // reset state
    check("rst_req_ready", mst_req_ready_o, 2'b11);
    check("rst_core_valid", core_dmi_valid_o, 1'b0);
    check("rst_resp_valid", mst_resp_valid_o, 2'b00);
    check("rst_core_ready", core_dmi_ready_o, 1'b0);
    check("rst_unexp", unexp_resp_o, 1'b0);
    rst_i = 0;

    // T1: three back-to-back requests on ch0, core always ready
    clear_logs();
    core_dmi_ready_i = 1;
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      mst_req_valid_i = 2'b01;
      mst_req_i[0] = mk_req(0, k);
      if (k == 0) t0 = cyc;
      step();
    end
    mst_req_valid_i = '0;
    step(2);
    check("t1_n_issued", iss_ch.size(), 3);
    for (int k = 0; k < 3 && k < iss_ch.size(); k++) begin
      check("t1_issue_ch", iss_ch[k], 0);
      check("t1_issue_cyc", iss_cyc[k] - t0, k + 1);
      check("t1_issue_dat", iss_dat[k], mk_req(0, k));
    end
    for (int k = 0; k < 3; k++) begin
      core_dmi_valid_i = 1;
      core_dmi_resp_i = mk_resp(k);
      #1;
      check("t1_resp_valid", mst_resp_valid_o, 2'b01);
      check("t1_resp_dat", mst_resp_o[0], mk_resp(k));
      step();
    end
    core_dmi_valid_i = 0;
    step();
    check("t1_n_delivered", del_ch.size(), 3);

    // T2: both channels hold two requests, rr starts at 0
    do_reset();
    clear_logs();
    core_dmi_ready_i = 0;
    for (int k = 0; k < 2; k++) begin
      mst_req_valid_i = 2'b11;
      mst_req_i[0] = mk_req(0, k);
      mst_req_i[1] = mk_req(1, k);
      step();
    end
    mst_req_valid_i = '0;
    step();
    core_dmi_ready_i = 1;
    step(5);
    exp_ch2 = '{0, 1, 0, 1};
    exp_rv2 = '{1, 2, 1, 2};
    check("t2_n_issued", iss_ch.size(), 4);
    for (int k = 0; k < 4 && k < iss_ch.size(); k++) begin
      check("t2_issue_ch", iss_ch[k], exp_ch2[k]);
      check("t2_issue_dat", iss_dat[k], mk_req(exp_ch2[k], k / 2));
    end
    for (int k = 0; k < 4; k++) begin
      core_dmi_valid_i = 1;
      core_dmi_resp_i = mk_resp(20 + k);
      #1;
      check("t2_resp_valid", mst_resp_valid_o, exp_rv2[k]);
      step();
    end
    core_dmi_valid_i = 0;
    step();
    check("t2_n_delivered", del_ch.size(), 4);

    // T3: stalled offer on ch0 (rr=1) is not preempted by a new ch1 request
    do_reset();
    clear_logs();
    core_dmi_ready_i = 1;
    mst_req_valid_i = 2'b01;
    mst_req_i[0] = mk_req(0, 5);
    step();
    mst_req_valid_i = '0;
    step(2);
    core_dmi_ready_i = 0;
    mst_req_valid_i = 2'b01;
    mst_req_i[0] = mk_req(0, 6);
    step();
    mst_req_valid_i = '0;
    step();
    mst_req_valid_i = 2'b10;
    mst_req_i[1] = mk_req(1, 6);
    step();
    mst_req_valid_i = '0;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", core_dmi_valid_o, 1'b1);
      check("t3_hold_req", core_dmi_req_o, mk_req(0, 6));
      step();
    end
    core_dmi_ready_i = 1;
    step(3);
    check("t3_n_issued", iss_ch.size(), 3);
    if (iss_ch.size() == 3) begin
      check("t3_issue1_ch", iss_ch[1], 0);
      check("t3_issue2_ch", iss_ch[2], 1);
    end
    drain(3);

    // T4: ch0 full with core stalled; pop and push in the same cycle
    do_reset();
    clear_logs();
    core_dmi_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      mst_req_valid_i = 2'b01;
      mst_req_i[0] = mk_req(0, 10 + k);
      step();
    end
    check("t4_full_ready", mst_req_ready_o, 2'b10);
    mst_req_i[0] = mk_req(0, 20);
    core_dmi_ready_i = 1;
    check("t4_popcycle_ready", mst_req_ready_o, 2'b10);
    step();
    core_dmi_ready_i = 0;
    mst_req_valid_i = '0;
    check("t4_after_pop_ready", mst_req_ready_o, 2'b11);
    core_dmi_ready_i = 1;
    step(5);
    check("t4_n_issued", iss_ch.size(), 4);
    if (iss_ch.size() == 4) check("t4_last_dat", iss_dat[3], mk_req(0, 13));
    drain(4);

    // T5: MaxOutstanding reached blocks issue; first response re-enables it
    do_reset();
    clear_logs();
    core_dmi_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      mst_req_valid_i = 2'b01;
      mst_req_i[0] = mk_req(0, 30 + k);
      step();
    end
    mst_req_valid_i = '0;
    step(2);
    check("t5_blocked_valid", core_dmi_valid_o, 1'b0);
    check("t5_n_issued", iss_ch.size(), 4);
    core_dmi_valid_i = 1;
    core_dmi_resp_i = mk_resp(7);
    #1;
    check("t5_same_cycle_valid", core_dmi_valid_o, 1'b0);
    step();
    core_dmi_valid_i = 0;
    check("t5_reenabled_valid", core_dmi_valid_o, 1'b1);
    step();
    check("t5_n_issued_after", iss_ch.size(), 5);
    drain(4);

    // T6: unexpected response, then reset in the middle of traffic
    do_reset();
    clear_logs();
    core_dmi_ready_i = 0;
    core_dmi_valid_i = 1;
    core_dmi_resp_i = mk_resp(9);
    #1;
    check("t6_unexp_ready", core_dmi_ready_o, 1'b1);
    check("t6_unexp_pulse", unexp_resp_o, 1'b1);
    check("t6_unexp_no_mvalid", mst_resp_valid_o, 2'b00);
    step();
    core_dmi_valid_i = 0;
    #1;
    check("t6_unexp_done", unexp_resp_o, 1'b0);
    core_dmi_ready_i = 1;
    mst_req_valid_i = 2'b01;
    mst_req_i[0] = mk_req(0, 40);
    step();
    mst_req_valid_i = '0;
    step(2);
    core_dmi_ready_i = 0;
    mst_req_valid_i = 2'b11;
    mst_req_i[0] = mk_req(0, 41);
    mst_req_i[1] = mk_req(1, 41);
    step();
    mst_req_valid_i = '0;
    step();
    mst_resp_ready_i = 2'b00;
    core_dmi_valid_i = 1;
    #1;
    check("t6_inflight_mvalid", mst_resp_valid_o, 2'b01);
    check("t6_inflight_cvalid", core_dmi_valid_o, 1'b1);
    rst_i = 1;
    step();
    check("t6_rst_cvalid", core_dmi_valid_o, 1'b0);
    check("t6_rst_mvalid", mst_resp_valid_o, 2'b00);
    check("t6_rst_req_ready", mst_req_ready_o, 2'b11);
    rst_i = 0;
    core_dmi_valid_i = 0;
    mst_resp_ready_i = 2'b11;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
